// File: rtl/bsg_popcount_seq.sv
// Sequential popcount: counts a wide vector slice_p bits per cycle.
// Define BSG_POPCOUNT_SEQ_EARLY_EXIT_EN to stop once the remaining bits are zero.

module bsg_popcount #(
  parameter int width_p = 4
) (
  input  logic [width_p-1:0]         a_i,
  output logic [$clog2(width_p+1)-1:0] num_o
);

  localparam int nw_lp = $clog2(width_p+1);

  always_comb begin
    num_o = '0;
    for (int i = 0; i < width_p; i++) begin
      num_o = num_o + nw_lp'(a_i[i]);
    end
  end

endmodule

module bsg_popcount_seq #(
  parameter int width_p = 16,
  parameter int slice_p = 4
) (
  input  logic                         clk_i,
  input  logic                         reset_i,
  input  logic [width_p-1:0]           data_i,
  input  logic                         v_i,
  output logic                         ready_o,
  output logic [$clog2(width_p+1)-1:0] count_o,
  output logic                         v_o,
  input  logic                         yumi_i
);

  localparam int beats_lp = (width_p + slice_p - 1) / slice_p;
  localparam int cw_lp    = $clog2(width_p+1);
  localparam int pw_lp    = $clog2(slice_p+1);
  localparam int bw_lp    = (beats_lp > 1) ? $clog2(beats_lp) : 1;

  localparam logic [bw_lp-1:0] last_beat_lp = bw_lp'(beats_lp-1);

  typedef enum logic [1:0] {
    eIdle,
    eBusy,
    eDone
  } state_e;

  state_e state_r, state_n;

  logic [width_p-1:0] shift_r;
  logic [width_p-1:0] shift_n;
  logic [cw_lp-1:0]   acc_r;
  logic [bw_lp-1:0]   beat_r;
  logic [pw_lp-1:0]   slice_cnt;
  logic               accept;
  logic               last_beat;

  assign accept  = v_i & ready_o;
  // Logical shift zero-fills, so a partial last slice adds nothing extra
  assign shift_n = shift_r >> slice_p;

  bsg_popcount #(
    .width_p(slice_p)
  ) pc (
    .a_i  (shift_r[slice_p-1:0]),
    .num_o(slice_cnt)
  );

`ifdef BSG_POPCOUNT_SEQ_EARLY_EXIT_EN
  assign last_beat = (beat_r == last_beat_lp)
                   | (shift_n == '0);
`else
  assign last_beat = (beat_r == last_beat_lp);
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r <= eIdle;
    end else begin
      state_r <= state_n;
    end
  end

  always_comb begin
    state_n = state_r;
    unique case (state_r)
      eIdle: begin
        if (v_i) state_n = eBusy;
      end
      eBusy: begin
        if (last_beat) state_n = eDone;
      end
      eDone: begin
        if (yumi_i) state_n = eIdle;
      end
      default: state_n = eIdle;
    endcase
  end

  always_comb begin
    ready_o = 1'b0;
    v_o     = 1'b0;
    count_o = '0;
    unique case (state_r)
      eIdle: ready_o = 1'b1;
      eDone: begin
        v_o     = 1'b1;
        count_o = acc_r;
      end
      default: ;
    endcase
  end

  // Sum never exceeds width_p, so cw_lp bits cannot overflow
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      shift_r <= '0;
      acc_r   <= '0;
      beat_r  <= '0;
    end else if (accept) begin
      shift_r <= data_i;
      acc_r   <= '0;
      beat_r  <= '0;
    end else if (state_r == eBusy) begin
      shift_r <= shift_n;
      acc_r   <= acc_r + cw_lp'(slice_cnt);
      beat_r  <= beat_r + 1'b1;
    end
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk_i) begin
    if (!reset_i && yumi_i) begin
      assert (state_r == eDone)
        else $error("bsg_popcount_seq: yumi_i without v_o");
    end
  end
`endif

endmodule
